// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencing FSM and its register-select decoder.
package alu_seq_pkg;

   localparam int NREG_DEF  = 6;
   localparam int IDX_W_DEF = 6;

   localparam logic [3:0] ALU_OP_MIN = 4'b1001;
   localparam logic [3:0] ALU_OP_MAX = 4'b1111;
   localparam logic [3:0] OP_NOT     = 4'b1111;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FETCH = 4'd1,
      S_OP1   = 4'd2,
      S_GAP   = 4'd3,
      S_SRC2  = 4'd4,
      S_OP2   = 4'd5,
      S_LATCH = 4'd6,
      S_DRIVE = 4'd7,
      S_WB    = 4'd8,
      S_DONE  = 4'd9,
      S_ERR   = 4'd10
   } state_t;

   // True for any opcode the ALU sequencer knows how to run.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op inside {[ALU_OP_MIN:ALU_OP_MAX]};
   endfunction

   // NOT is the only single-operand ALU operation.
   function automatic logic is_unary_op(input logic [3:0] op);
      return op == OP_NOT;
   endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// Turns a register index into a one-hot enable vector, flagging indices beyond the file.
module reg_sel_dec
   import alu_seq_pkg::*;
#(
   parameter int NREG  = NREG_DEF,
   parameter int IDX_W = IDX_W_DEF
) (
   input  logic [IDX_W-1:0] idx,
   output logic [NREG-1:0]  one_hot,
   output logic             valid
);

   // An out-of-range index lights no bit and clears valid.
   always_comb begin
      one_hot = '0;
      valid   = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         if (int'(idx) == i) begin
            one_hot[i] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq_fsm.sv
// Microsequencer driving register-file and ALU control strobes for one ALU instruction.
module alu_seq_fsm
   import alu_seq_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int IDX_W   = IDX_W_DEF,
   parameter int INSTR_W = 4 + 2*IDX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr,
   input  logic               start,
   input  logic               flush,
   output logic [NREG-1:0]    reg_out_en,
   output logic [NREG-1:0]    reg_in_en,
   output logic               pc_inc,
   output logic               alu_in1,
   output logic               alu_in2,
   output logic               alu_out_latch,
   output logic               alu_out_en,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_t             state;
   state_t             state_next;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] instr_cur;
   logic [3:0]         opcode;
   logic [IDX_W-1:0]   idx_a;
   logic [IDX_W-1:0]   idx_b;
   logic               unary;
   logic [NREG-1:0]    a_one_hot;
   logic [NREG-1:0]    b_one_hot;
   logic               a_valid;
   logic               b_valid;
   logic               operands_ok;
   logic               accept;

   // While idle the incoming word is inspected so a bad index can jump straight to ERR;
   // once running, everything decodes from the captured copy only.
   assign instr_cur   = (state == S_IDLE) ? instr : instr_q;
   assign opcode      = instr_cur[INSTR_W-1 -: 4];
   assign idx_a       = instr_cur[2*IDX_W-1:IDX_W];
   assign idx_b       = instr_cur[IDX_W-1:0];
   assign unary       = is_unary_op(opcode);
   assign operands_ok = a_valid && (unary || b_valid);
   assign accept      = (state == S_IDLE) && start && !flush && is_alu_op(opcode);

   reg_sel_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_dst_dec (
      .idx     (idx_a),
      .one_hot (a_one_hot),
      .valid   (a_valid)
   );

   reg_sel_dec #(.NREG(NREG), .IDX_W(IDX_W)) u_src_dec (
      .idx     (idx_b),
      .one_hot (b_one_hot),
      .valid   (b_valid)
   );

   // State register and instruction capture; reset wipes both.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         instr_q <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            instr_q <= instr;
         end
      end
   end

   // Step through the operand/result sequence; flush always wins and stray encodings recover.
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept) state_next = operands_ok ? S_FETCH : S_ERR;
            S_FETCH: state_next = S_OP1;
            S_OP1:   state_next = unary ? S_LATCH : S_GAP;
            S_GAP:   state_next = S_SRC2;
            S_SRC2:  state_next = S_OP2;
            S_OP2:   state_next = S_LATCH;
            S_LATCH: state_next = S_DRIVE;
            S_DRIVE: state_next = S_WB;
            S_WB:    state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Control strobes per state; held quiet while reset is asserted.
   always_comb begin
      reg_out_en    = '0;
      reg_in_en     = '0;
      pc_inc        = 1'b0;
      alu_in1       = 1'b0;
      alu_in2       = 1'b0;
      alu_out_latch = 1'b0;
      alu_out_en    = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               busy       = 1'b1;
               pc_inc     = 1'b1;
               reg_out_en = a_one_hot;
            end
            S_OP1: begin
               busy       = 1'b1;
               reg_out_en = a_one_hot;
               alu_in1    = 1'b1;
            end
            S_GAP: begin
               busy = 1'b1;
            end
            S_SRC2: begin
               busy       = 1'b1;
               reg_out_en = b_one_hot;
            end
            S_OP2: begin
               busy       = 1'b1;
               reg_out_en = b_one_hot;
               alu_in2    = 1'b1;
            end
            S_LATCH: begin
               busy          = 1'b1;
               alu_out_latch = 1'b1;
            end
            S_DRIVE: begin
               busy       = 1'b1;
               alu_out_en = 1'b1;
            end
            S_WB: begin
               busy       = 1'b1;
               alu_out_en = 1'b1;
               reg_in_en  = a_one_hot;
            end
            S_DONE: begin
               busy = 1'b1;
               done = 1'b1;
            end
            S_ERR: begin
               busy = 1'b1;
               done = 1'b1;
               err  = 1'b1;
            end
            default: begin
               busy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_fsm.sv
// Directed bench for alu_seq_fsm: a 6-register instance plus an 8-register instance.
module tb_alu_seq_fsm;

   // Expected control byte: {pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en, busy, done, err}
   localparam logic [7:0] C_IDLE  = 8'b0000_0000;
   localparam logic [7:0] C_FETCH = 8'b1000_0100;
   localparam logic [7:0] C_OP1   = 8'b0100_0100;
   localparam logic [7:0] C_GAP   = 8'b0000_0100;
   localparam logic [7:0] C_SRC2  = 8'b0000_0100;
   localparam logic [7:0] C_OP2   = 8'b0010_0100;
   localparam logic [7:0] C_LATCH = 8'b0001_0100;
   localparam logic [7:0] C_DRIVE = 8'b0000_1100;
   localparam logic [7:0] C_WB    = 8'b0000_1100;
   localparam logic [7:0] C_DONE  = 8'b0000_0110;
   localparam logic [7:0] C_ERR   = 8'b0000_0111;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic        start;
   logic        flush;
   logic [5:0]  reg_out_en;
   logic [5:0]  reg_in_en;
   logic        pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en, busy, done, err;

   logic [15:0] instr8;
   logic        start8;
   logic        flush8;
   logic [7:0]  reg_out_en8;
   logic [7:0]  reg_in_en8;
   logic        pc_inc8, alu_in1_8, alu_in2_8, alu_out_latch8, alu_out_en8, busy8, done8, err8;

   logic [7:0]  ctl6;
   logic [7:0]  ctl8;

   int checks = 0;
   int errors = 0;

   assign ctl6 = {pc_inc, alu_in1, alu_in2, alu_out_latch, alu_out_en, busy, done, err};
   assign ctl8 = {pc_inc8, alu_in1_8, alu_in2_8, alu_out_latch8, alu_out_en8, busy8, done8, err8};

   alu_seq_fsm dut (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr),
      .start         (start),
      .flush         (flush),
      .reg_out_en    (reg_out_en),
      .reg_in_en     (reg_in_en),
      .pc_inc        (pc_inc),
      .alu_in1       (alu_in1),
      .alu_in2       (alu_in2),
      .alu_out_latch (alu_out_latch),
      .alu_out_en    (alu_out_en),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   alu_seq_fsm #(.NREG(8), .IDX_W(6), .INSTR_W(16)) dut8 (
      .clk           (clk),
      .rst           (rst),
      .instr         (instr8),
      .start         (start8),
      .flush         (flush8),
      .reg_out_en    (reg_out_en8),
      .reg_in_en     (reg_in_en8),
      .pc_inc        (pc_inc8),
      .alu_in1       (alu_in1_8),
      .alu_in2       (alu_in2_8),
      .alu_out_latch (alu_out_latch8),
      .alu_out_en    (alu_out_en8),
      .busy          (busy8),
      .done          (done8),
      .err           (err8)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Advance one cycle and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare every output of the chosen instance against hand-derived values.
   task automatic checkOutput(input string tag, input bit wide,
                              input logic [7:0] oe_exp, input logic [7:0] ie_exp,
                              input logic [7:0] ctl_exp);
      logic [23:0] got;
      logic [23:0] want;
      if (wide) got = {reg_out_en8, reg_in_en8, ctl8};
      else      got = {2'b00, reg_out_en, 2'b00, reg_in_en, ctl6};
      want = {oe_exp, ie_exp, ctl_exp};
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s observed=%06h expected=%06h", tag, got, want);
      end
   endtask

   // Full binary op with per-cycle checks; optionally pokes start and instr mid-flight.
   task automatic applyStimulus(input string tag, input bit wide, input logic [15:0] ins,
                                input logic [7:0] s1, input logic [7:0] s2, input bit poke);
      if (wide) begin
         instr8 = ins;
         start8 = 1'b1;
      end else begin
         instr = ins;
         start = 1'b1;
      end
      tick();
      start  = 1'b0;
      start8 = 1'b0;
      checkOutput({tag, "_c1_fetch"}, wide, s1, 8'h00, C_FETCH);
      if (poke) begin
         start = 1'b1;
         instr = 16'hF100;
      end
      tick();
      start = 1'b0;
      checkOutput({tag, "_c2_op1"}, wide, s1, 8'h00, C_OP1);
      tick();
      checkOutput({tag, "_c3_gap"}, wide, 8'h00, 8'h00, C_GAP);
      tick();
      checkOutput({tag, "_c4_src2"}, wide, s2, 8'h00, C_SRC2);
      tick();
      checkOutput({tag, "_c5_op2"}, wide, s2, 8'h00, C_OP2);
      tick();
      checkOutput({tag, "_c6_latch"}, wide, 8'h00, 8'h00, C_LATCH);
      tick();
      checkOutput({tag, "_c7_drive"}, wide, 8'h00, 8'h00, C_DRIVE);
      tick();
      checkOutput({tag, "_c8_wb"}, wide, 8'h00, s1, C_WB);
      tick();
      checkOutput({tag, "_c9_done"}, wide, 8'h00, 8'h00, C_DONE);
      tick();
      checkOutput({tag, "_c10_idle"}, wide, 8'h00, 8'h00, C_IDLE);
   endtask

   // Directed sequence covering reset, binary/unary ops, errors, aborts and the wide instance.
   initial begin
      rst    = 1'b1;
      instr  = 16'h0000;
      start  = 1'b0;
      flush  = 1'b0;
      instr8 = 16'h0000;
      start8 = 1'b0;
      flush8 = 1'b0;
      tick();
      tick();
      checkOutput("reset6", 1'b0, 8'h00, 8'h00, C_IDLE);
      checkOutput("reset8", 1'b1, 8'h00, 8'h00, C_IDLE);
      rst = 1'b0;
      tick();

      applyStimulus("add_2_3", 1'b0, 16'h9083, 8'h04, 8'h08, 1'b0);

      instr = 16'hF100;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("not4_c1_fetch", 1'b0, 8'h10, 8'h00, C_FETCH);
      tick();
      checkOutput("not4_c2_op1", 1'b0, 8'h10, 8'h00, C_OP1);
      tick();
      checkOutput("not4_c3_latch", 1'b0, 8'h00, 8'h00, C_LATCH);
      tick();
      checkOutput("not4_c4_drive", 1'b0, 8'h00, 8'h00, C_DRIVE);
      tick();
      checkOutput("not4_c5_wb", 1'b0, 8'h00, 8'h10, C_WB);
      tick();
      checkOutput("not4_c6_done", 1'b0, 8'h00, 8'h00, C_DONE);
      tick();
      checkOutput("not4_c7_idle", 1'b0, 8'h00, 8'h00, C_IDLE);

      instr = 16'h9187;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("badidx_c1_err", 1'b0, 8'h00, 8'h00, C_ERR);
      tick();
      checkOutput("badidx_c2_idle", 1'b0, 8'h00, 8'h00, C_IDLE);

      instr = 16'h1083;
      start = 1'b1;
      tick();
      checkOutput("nonalu_c1", 1'b0, 8'h00, 8'h00, C_IDLE);
      tick();
      start = 1'b0;
      checkOutput("nonalu_c2", 1'b0, 8'h00, 8'h00, C_IDLE);

      applyStimulus("poke", 1'b0, 16'h9083, 8'h04, 8'h08, 1'b1);

      instr = 16'h9083;
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      checkOutput("flush_beats_start", 1'b0, 8'h00, 8'h00, C_IDLE);

      instr = 16'h9083;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("flush_c1", 1'b0, 8'h04, 8'h00, C_FETCH);
      tick();
      tick();
      checkOutput("flush_c3", 1'b0, 8'h00, 8'h00, C_GAP);
      tick();
      checkOutput("flush_c4", 1'b0, 8'h08, 8'h00, C_SRC2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_c5_idle", 1'b0, 8'h00, 8'h00, C_IDLE);
      tick();
      checkOutput("flush_c6_nodone", 1'b0, 8'h00, 8'h00, C_IDLE);

      instr = 16'h9083;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checkOutput("rst_c6_latch", 1'b0, 8'h00, 8'h00, C_LATCH);
      rst = 1'b1;
      tick();
      checkOutput("rst_c7_zero", 1'b0, 8'h00, 8'h00, C_IDLE);
      rst = 1'b0;
      tick();
      checkOutput("rst_c8_idle", 1'b0, 8'h00, 8'h00, C_IDLE);

      applyStimulus("after_rst", 1'b0, 16'h9083, 8'h04, 8'h08, 1'b0);

      applyStimulus("wide_7_6", 1'b1, 16'hA1C6, 8'h80, 8'h40, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
